// File: rtl/ime_job_arb_pkg.sv
// Shared widths for the IME job arbiter and the engine command bus.
// The per-command field width is shared with ime_ctrl; FSM encodings stay local to the arbiter.
package ime_job_arb_pkg;

  localparam int IME_MV_WIDTH_X     = 7;
  localparam int IME_MV_WIDTH_Y     = 6;
  localparam int IME_CMD_WIDTH      = IME_MV_WIDTH_X + IME_MV_WIDTH_Y;
  localparam int IME_CMD_PER_JOB    = 8;
  localparam int IME_CMD_DAT_WIDTH  = IME_CMD_PER_JOB * IME_CMD_WIDTH;
  localparam int IME_CMD_NUM_WIDTH  = 3;

  // Increment an index, wrapping at n so non-power-of-two requester counts never overshoot.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ime_rr_pick.sv
// Combinational round-robin picker: rotate the request vector so ptr sits at bit 0,
// take the lowest set bit, then rotate the offset back into an absolute requester index.
module ime_rr_pick #(
  parameter int REQ_NUM       = 4,
  parameter int REQ_IDX_WIDTH = 2
) (
  input  logic [REQ_NUM-1:0]       req_i,
  input  logic [REQ_IDX_WIDTH-1:0] ptr_i,
  output logic                     valid_o,
  output logic [REQ_IDX_WIDTH-1:0] idx_o
);

  logic [REQ_NUM-1:0] rot;
  int                 src;
  int                 off;
  int                 absIdx;
  logic               found;

  // Rotate, find the first pending requester at or after ptr, and map it back to its index.
  always_comb begin
    rot    = '0;
    src    = 0;
    off    = 0;
    absIdx = 0;
    found  = 1'b0;
    for (int i = 0; i < REQ_NUM; i++) begin
      src = i + int'(ptr_i);
      if (src >= REQ_NUM) src = src - REQ_NUM;
      rot[i] = req_i[src];
    end
    for (int i = 0; i < REQ_NUM; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = i;
      end
    end
    absIdx = off + int'(ptr_i);
    if (absIdx >= REQ_NUM) absIdx = absIdx - REQ_NUM;
    valid_o = found;
    idx_o   = REQ_IDX_WIDTH'(absIdx);
  end

endmodule

// File: rtl/ime_job_arb.sv
// Round-robin sequencer sharing one IME engine among REQ_NUM requesters.
// One job at a time walks IDLE -> LATCH -> START -> WAIT -> ACK; every output is a flop.
module ime_job_arb
  import ime_job_arb_pkg::*;
#(
  parameter int REQ_NUM       = 4,
  parameter int REQ_IDX_WIDTH = 2,
  parameter int CMD_NUM_WIDTH = IME_CMD_NUM_WIDTH,
  parameter int CMD_DAT_WIDTH = IME_CMD_DAT_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [REQ_NUM-1:0]                 req_i,
  input  logic [REQ_NUM*CMD_NUM_WIDTH-1:0]   cmd_num_i,
  input  logic [REQ_NUM*CMD_DAT_WIDTH-1:0]   cmd_dat_i,
  output logic [REQ_NUM-1:0]                 gnt_o,
  output logic [REQ_NUM-1:0]                 ack_o,
  output logic                               busy_o,
  output logic                               ime_start_o,
  input  logic                               ime_done_i,
  output logic [CMD_NUM_WIDTH-1:0]           ime_cmd_num_o,
  output logic [CMD_DAT_WIDTH-1:0]           ime_cmd_dat_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_ACK   = 3'd4
  } state_e;

  state_e                     state_q, state_d;
  logic [REQ_IDX_WIDTH-1:0]   ptr_q, ptr_d;
  logic [REQ_IDX_WIDTH-1:0]   winner_q, winner_d;
  logic [REQ_NUM-1:0]         gnt_q, gnt_d;
  logic [REQ_NUM-1:0]         ack_q, ack_d;
  logic                       busy_q, busy_d;
  logic                       start_q, start_d;
  logic [CMD_NUM_WIDTH-1:0]   cmd_num_q, cmd_num_d;
  logic [CMD_DAT_WIDTH-1:0]   cmd_dat_q, cmd_dat_d;

  logic                       pick_valid;
  logic [REQ_IDX_WIDTH-1:0]   pick_idx;

  ime_rr_pick #(
    .REQ_NUM       (REQ_NUM),
    .REQ_IDX_WIDTH (REQ_IDX_WIDTH)
  ) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // State register; reset abandons any job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: one job per pass; done is only honoured while waiting on the engine.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (pick_valid) state_d = S_LATCH;
      S_LATCH: state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (ime_done_i) state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values: grant on pick, latch cmds in LATCH, ack on done, rotate ptr in ACK.
  always_comb begin
    ptr_d     = ptr_q;
    winner_d  = winner_q;
    gnt_d     = gnt_q;
    ack_d     = '0;
    start_d   = 1'b0;
    busy_d    = (state_d != S_IDLE);
    cmd_num_d = cmd_num_q;
    cmd_dat_d = cmd_dat_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          winner_d = pick_idx;
          for (int k = 0; k < REQ_NUM; k++) begin
            gnt_d[k] = (pick_idx == REQ_IDX_WIDTH'(k));
          end
        end
      end
      S_LATCH: begin
        start_d = 1'b1;
        for (int k = 0; k < REQ_NUM; k++) begin
          if (winner_q == REQ_IDX_WIDTH'(k)) begin
            cmd_num_d = cmd_num_i[k*CMD_NUM_WIDTH +: CMD_NUM_WIDTH];
            cmd_dat_d = cmd_dat_i[k*CMD_DAT_WIDTH +: CMD_DAT_WIDTH];
          end
        end
      end
      S_START: ;
      S_WAIT: begin
        if (ime_done_i) ack_d = gnt_q;
      end
      S_ACK: begin
        gnt_d = '0;
        ptr_d = REQ_IDX_WIDTH'(wrap_inc(int'(winner_q), REQ_NUM));
      end
      default: ;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= '0;
      winner_q  <= '0;
      gnt_q     <= '0;
      ack_q     <= '0;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      cmd_num_q <= '0;
      cmd_dat_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      winner_q  <= winner_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      start_q   <= start_d;
      cmd_num_q <= cmd_num_d;
      cmd_dat_q <= cmd_dat_d;
    end
  end

  assign gnt_o         = gnt_q;
  assign ack_o         = ack_q;
  assign busy_o        = busy_q;
  assign ime_start_o   = start_q;
  assign ime_cmd_num_o = cmd_num_q;
  assign ime_cmd_dat_o = cmd_dat_q;

endmodule

// File: tb/tb_ime_job_arb.sv
// Directed plus randomized bench for ime_job_arb against a round-robin service model.
module tb_ime_job_arb;
  import ime_job_arb_pkg::*;

  localparam int N  = 4;
  localparam int NW = IME_CMD_NUM_WIDTH;
  localparam int DW = IME_CMD_DAT_WIDTH;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       req_i;
  logic [N*NW-1:0]    cmd_num_i;
  logic [N*DW-1:0]    cmd_dat_i;
  logic [N-1:0]       gnt_o;
  logic [N-1:0]       ack_o;
  logic               busy_o;
  logic               ime_start_o;
  logic               ime_done_i;
  logic [NW-1:0]      ime_cmd_num_o;
  logic [DW-1:0]      ime_cmd_dat_o;

  int                 testCount = 0;
  int                 failCount = 0;
  int                 ptrModel  = 0;
  int                 lastWinner;
  logic [NW-1:0]      expNum;
  logic [DW-1:0]      expDat;

  ime_job_arb #(
    .REQ_NUM       (N),
    .REQ_IDX_WIDTH (2),
    .CMD_NUM_WIDTH (NW),
    .CMD_DAT_WIDTH (DW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_i         (req_i),
    .cmd_num_i     (cmd_num_i),
    .cmd_dat_i     (cmd_dat_i),
    .gnt_o         (gnt_o),
    .ack_o         (ack_o),
    .busy_o        (busy_o),
    .ime_start_o   (ime_start_o),
    .ime_done_i    (ime_done_i),
    .ime_cmd_num_o (ime_cmd_num_o),
    .ime_cmd_dat_o (ime_cmd_dat_o)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  // Round-robin rule: first requester found scanning p, p+1, ... modulo N.
  function automatic int pickWinner(input logic [N-1:0] req, input int p);
    for (int k = 0; k < N; k++) begin
      if (req[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] v;
    v = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [N-1:0] req, input logic done);
    req_i      = req;
    ime_done_i = done;
  endtask

  task automatic randomCmd();
    cmd_num_i = (N*NW)'($urandom());
    for (int i = 0; i < (N*DW)/32; i++) cmd_dat_i[i*32 +: 32] = $urandom();
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_gnt"},   128'(gnt_o),       128'(0));
    checkOutput({tag, "_ack"},   128'(ack_o),       128'(0));
    checkOutput({tag, "_busy"},  128'(busy_o),      128'(0));
    checkOutput({tag, "_start"}, 128'(ime_start_o), 128'(0));
  endtask

  // One complete job from an IDLE-cycle negedge back to the following IDLE-cycle negedge.
  task automatic runJob(input string tag, input logic [N-1:0] reqV, input int waitCycles,
                        input bit spuriousInStart, input bit mutateInWait, input bit keepCmd,
                        input logic [N-1:0] reqInWait, output int winner);
    int w;
    w = pickWinner(reqV, ptrModel);
    winner = w;
    if (!keepCmd) randomCmd();
    applyStimulus(reqV, 1'b0);
    expNum = cmd_num_i[w*NW +: NW];
    expDat = cmd_dat_i[w*DW +: DW];
    tick();
    checkOutput({tag, "_latch_gnt"},   128'(gnt_o),       128'(onehot(w)));
    checkOutput({tag, "_latch_busy"},  128'(busy_o),      128'(1));
    checkOutput({tag, "_latch_start"}, 128'(ime_start_o), 128'(0));
    tick();
    checkOutput({tag, "_start_pulse"}, 128'(ime_start_o),   128'(1));
    checkOutput({tag, "_start_num"},   128'(ime_cmd_num_o), 128'(expNum));
    checkOutput({tag, "_start_dat"},   128'(ime_cmd_dat_o), 128'(expDat));
    checkOutput({tag, "_start_ack"},   128'(ack_o),         128'(0));
    if (spuriousInStart) ime_done_i = 1'b1;
    tick();
    applyStimulus(reqInWait, 1'b0);
    checkOutput({tag, "_wait_start"}, 128'(ime_start_o), 128'(0));
    checkOutput({tag, "_wait_ack"},   128'(ack_o),       128'(0));
    checkOutput({tag, "_wait_busy"},  128'(busy_o),      128'(1));
    if (mutateInWait) begin
      cmd_num_i = ~cmd_num_i;
      cmd_dat_i = ~cmd_dat_i;
    end
    for (int i = 0; i < waitCycles; i++) begin
      tick();
      checkOutput({tag, "_hold_ack"}, 128'(ack_o), 128'(0));
      checkOutput({tag, "_hold_gnt"}, 128'(gnt_o), 128'(onehot(w)));
    end
    ime_done_i = 1'b1;
    tick();
    ime_done_i = 1'b0;
    checkOutput({tag, "_ack_pulse"}, 128'(ack_o),         128'(onehot(w)));
    checkOutput({tag, "_ack_gnt"},   128'(gnt_o),         128'(onehot(w)));
    checkOutput({tag, "_ack_num"},   128'(ime_cmd_num_o), 128'(expNum));
    checkOutput({tag, "_ack_dat"},   128'(ime_cmd_dat_o), 128'(expDat));
    tick();
    checkIdle({tag, "_done"});
    checkOutput({tag, "_done_dat"}, 128'(ime_cmd_dat_o), 128'(expDat));
    ptrModel = (w + 1) % N;
  endtask

  // Directed scenarios followed by a randomized run, all in one linear sequence.
  initial begin
    rst = 1'b1;
    applyStimulus('0, 1'b0);
    cmd_num_i = '0;
    cmd_dat_i = '0;
    @(negedge clk);
    @(negedge clk);
    checkIdle("reset");
    checkOutput("reset_num", 128'(ime_cmd_num_o), 128'(0));
    checkOutput("reset_dat", 128'(ime_cmd_dat_o), 128'(0));
    rst = 1'b0;
    ptrModel = 0;
    tick();
    checkIdle("post_reset");

    // Single request from requester 2 with a known command count.
    randomCmd();
    cmd_num_i[2*NW +: NW] = NW'(3);
    runJob("single", 4'b0100, 1, 1'b0, 1'b0, 1'b1, 4'b0100, lastWinner);

    // Spurious done while idle must neither start nor ack anything.
    applyStimulus('0, 1'b1);
    tick();
    checkIdle("spur_idle");
    applyStimulus('0, 1'b0);
    tick();
    checkIdle("spur_idle2");

    // Spurious done in the START cycle; the real done in WAIT finishes the job.
    runJob("spur_start", 4'b0001, 2, 1'b1, 1'b0, 1'b0, 4'b0001, lastWinner);

    // Command inputs inverted during WAIT must not disturb the latched block.
    runJob("cmd_change", 4'b0010, 2, 1'b0, 1'b1, 1'b0, 4'b0010, lastWinner);

    // Requester 3 drops its request during WAIT; it is still acked, then requester 1 is served.
    runJob("req_drop", 4'b1010, 1, 1'b0, 1'b0, 1'b0, 4'b0010, lastWinner);
    runJob("after_drop", 4'b0010, 0, 1'b0, 1'b0, 1'b0, 4'b0010, lastWinner);

    // Asynchronous reset while the engine is busy.
    applyStimulus(4'b0100, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("pre_reset_busy", 128'(busy_o), 128'(1));
    #2 rst = 1'b1;
    #1;
    checkIdle("async_reset");
    checkOutput("async_reset_num", 128'(ime_cmd_num_o), 128'(0));
    checkOutput("async_reset_dat", 128'(ime_cmd_dat_o), 128'(0));
    applyStimulus(4'b1111, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    ptrModel = 0;

    // All four requesting from ptr 0: service order 0,1,2,3,0.
    for (int j = 0; j < 5; j++) begin
      runJob("all_req", 4'b1111, j % 3, 1'b0, 1'b0, 1'b0, 4'b1111, lastWinner);
    end

    // Randomized jobs with idle gaps, random waits and spurious dones.
    for (int j = 0; j < 40; j++) begin
      if ($urandom_range(0, 3) == 0) begin
        applyStimulus('0, 1'($urandom_range(0, 1)));
        tick();
        checkIdle("rnd_gap");
      end
      runJob("rnd", N'($urandom_range(1, 15)), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
             N'($urandom_range(0, 15)), lastWinner);
    end

    applyStimulus('0, 1'b0);
    tick();
    checkIdle("final");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
